// File: rtl/ud_count_monitor_pkg.sv
// Shared encodings for the up/down counter monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ud_count_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_t;

  localparam logic       UD_UP   = 1'b1;
  localparam logic       UD_DN   = 1'b0;
  localparam logic [2:0] CNT_MAX = 3'd7;
  localparam logic [2:0] CNT_MIN = 3'd0;

  // Value the counter must show after one edge from q in direction ud (mod 8).
  function automatic logic [2:0] next_count(input logic [2:0] q, input logic ud);
    return (ud == UD_UP) ? q + 3'd1 : q - 3'd1;
  endfunction

endpackage

// File: rtl/ud_count_monitor_sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: q reflects inc one cycle after the edge that sampled it.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, stop at the maximum, clear has priority over inc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/ud_count_monitor.sv
// Checks a 3-bit up/down counter steps by exactly +/-1 each cycle; flags errors, wraps, direction changes.
// Latency: every output is registered, valid the cycle after the edge that sampled the event.
// Backpressure: none; one sample consumed per clock, never stalls.
module ud_count_monitor
  import ud_count_monitor_pkg::*;
#(
  parameter int ERR_W       = 8,
  parameter int WRAP_W      = 8,
  parameter int FAULT_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              ud,
  input  logic              q2,
  input  logic              q1,
  input  logic              q0,
  output logic              step_err,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic              dir_chg,
  output logic              locked,
  output logic              fault,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt
);

  // consec is 4 bits because the fault limit may be as large as 15.
  localparam logic [3:0] FAULT_LIM4 = 4'(FAULT_LIMIT);

  logic [2:0] q_now;
  assign q_now = {q2, q1, q0};

  mon_state_t state, state_nxt;
  logic [2:0] q_prev, q_prev_nxt;
  logic       ud_prev, ud_prev_nxt;
  logic [3:0] consec, consec_nxt;
  logic       fault_nxt, locked_nxt;
  logic       step_err_nxt, wrap_up_nxt, wrap_dn_nxt, dir_chg_nxt;
  logic       err_inc, wrap_inc;

  // State, sample history and all registered flag outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      q_prev   <= '0;
      ud_prev  <= 1'b0;
      consec   <= '0;
      fault    <= 1'b0;
      locked   <= 1'b0;
      step_err <= 1'b0;
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      dir_chg  <= 1'b0;
    end else begin
      state    <= state_nxt;
      q_prev   <= q_prev_nxt;
      ud_prev  <= ud_prev_nxt;
      consec   <= consec_nxt;
      fault    <= fault_nxt;
      locked   <= locked_nxt;
      step_err <= step_err_nxt;
      wrap_up  <= wrap_up_nxt;
      wrap_dn  <= wrap_dn_nxt;
      dir_chg  <= dir_chg_nxt;
    end
  end

  // Next-state logic: clear wins over everything; FAULT is frozen until cleared.
  always_comb begin
    state_nxt    = state;
    q_prev_nxt   = q_prev;
    ud_prev_nxt  = ud_prev;
    consec_nxt   = consec;
    fault_nxt    = fault;
    step_err_nxt = 1'b0;
    wrap_up_nxt  = 1'b0;
    wrap_dn_nxt  = 1'b0;
    dir_chg_nxt  = 1'b0;
    err_inc      = 1'b0;
    wrap_inc     = 1'b0;

    if (clr) begin
      state_nxt  = IDLE;
      consec_nxt = '0;
      fault_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // First sample only seeds the history; nothing to compare against yet.
          if (en) begin
            q_prev_nxt  = q_now;
            ud_prev_nxt = ud;
            state_nxt   = TRACK;
          end
        end
        TRACK: begin
          if (!en) begin
            state_nxt  = IDLE;
            consec_nxt = '0;
          end else begin
            dir_chg_nxt = (ud != ud_prev);
            // Always resync to the sample so a skipped value costs one error only.
            q_prev_nxt  = q_now;
            ud_prev_nxt = ud;
            if (q_now != next_count(q_prev, ud_prev)) begin
              step_err_nxt = 1'b1;
              err_inc      = 1'b1;
              consec_nxt   = consec + 4'd1;
              if (consec_nxt == FAULT_LIM4) begin
                state_nxt = FAULT;
                fault_nxt = 1'b1;
              end
            end else begin
              consec_nxt  = '0;
              wrap_up_nxt = (q_prev == CNT_MAX) && (q_now == CNT_MIN) && (ud_prev == UD_UP);
              wrap_dn_nxt = (q_prev == CNT_MIN) && (q_now == CNT_MAX) && (ud_prev == UD_DN);
              wrap_inc    = wrap_up_nxt | wrap_dn_nxt;
            end
          end
        end
        FAULT: begin
          fault_nxt = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // Locked only once a real comparison has been made in TRACK and we stay there clean.
    locked_nxt = (state == TRACK) && (state_nxt == TRACK) && (consec_nxt == 4'd0);
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_inc),
    .q   (err_cnt)
  );

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wrap_inc),
    .q   (wrap_cnt)
  );

endmodule

// File: tb/tb_ud_count_monitor.sv
// Directed bench for ud_count_monitor with a reference model feeding an expectation queue.
// Latency: each driven sample is checked one cycle later, #1 after the sampling edge.
// Backpressure: n/a.
module tb_ud_count_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, clr, ud, q2, q1, q0;

  logic       step_err, wrap_up, wrap_dn, dir_chg, locked, fault;
  logic [7:0] err_cnt, wrap_cnt;

  logic       s_step_err, s_wrap_up, s_wrap_dn, s_dir_chg, s_locked, s_fault;
  logic [1:0] s_err_cnt;
  logic [7:0] s_wrap_cnt;

  ud_count_monitor #(.ERR_W(8), .WRAP_W(8), .FAULT_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ud(ud), .q2(q2), .q1(q1), .q0(q0),
    .step_err(step_err), .wrap_up(wrap_up), .wrap_dn(wrap_dn), .dir_chg(dir_chg),
    .locked(locked), .fault(fault), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  ud_count_monitor #(.ERR_W(2), .WRAP_W(8), .FAULT_LIMIT(3)) dut_small (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ud(ud), .q2(q2), .q1(q1), .q0(q0),
    .step_err(s_step_err), .wrap_up(s_wrap_up), .wrap_dn(s_wrap_dn), .dir_chg(s_dir_chg),
    .locked(s_locked), .fault(s_fault), .err_cnt(s_err_cnt), .wrap_cnt(s_wrap_cnt)
  );

  typedef struct packed {
    logic       step_err;
    logic       wrap_up;
    logic       wrap_dn;
    logic       dir_chg;
    logic       locked;
    logic       fault;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic [1:0] err_small;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: 0 = idle, 1 = tracking, 2 = faulted.
  int       m_state;
  logic [2:0] m_qp;
  logic     m_udp;
  int       m_consec, m_err, m_errs, m_wrap;
  logic     m_fault;

  task automatic model_reset();
    m_state = 0; m_qp = 3'd0; m_udp = 1'b0; m_consec = 0;
    m_err = 0; m_errs = 0; m_wrap = 0; m_fault = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  // Compute what the monitor must show after this sample and queue it.
  task automatic model_step(input logic e, input logic c, input logic u, input logic [2:0] q);
    exp_t x;
    int   prev_state;
    logic [2:0] want;
    x = '0;
    prev_state = m_state;
    if (c) begin
      m_state = 0; m_consec = 0; m_fault = 1'b0;
      m_err = 0; m_errs = 0; m_wrap = 0;
    end else if (m_state == 0) begin
      if (e) begin
        m_qp = q; m_udp = u; m_state = 1;
      end
    end else if (m_state == 1) begin
      if (!e) begin
        m_state = 0; m_consec = 0;
      end else begin
        want = m_udp ? 3'(m_qp + 3'd1) : 3'(m_qp - 3'd1);
        x.dir_chg = (u != m_udp);
        if (q != want) begin
          x.step_err = 1'b1;
          if (m_err < 255) m_err++;
          if (m_errs < 3) m_errs++;
          m_consec++;
          if (m_consec == 3) begin
            m_state = 2; m_fault = 1'b1;
          end
        end else begin
          m_consec = 0;
          x.wrap_up = (m_qp == 3'd7) && (q == 3'd0) && m_udp;
          x.wrap_dn = (m_qp == 3'd0) && (q == 3'd7) && !m_udp;
          if ((x.wrap_up || x.wrap_dn) && m_wrap < 255) m_wrap++;
        end
        m_qp = q; m_udp = u;
      end
    end
    x.locked    = (prev_state == 1) && (m_state == 1) && (m_consec == 0);
    x.fault     = m_fault;
    x.err_cnt   = 8'(m_err);
    x.wrap_cnt  = 8'(m_wrap);
    x.err_small = 2'(m_errs);
    exp_q.push_back(x);
  endtask

  task automatic step(input string lbl, input logic e, input logic c, input logic u, input logic [2:0] q);
    exp_t x;
    @(negedge clk);
    en = e; clr = c; ud = u; {q2, q1, q0} = q;
    model_step(e, c, u, q);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk({lbl, ".step_err"},  32'(step_err),  32'(x.step_err));
    chk({lbl, ".wrap_up"},   32'(wrap_up),   32'(x.wrap_up));
    chk({lbl, ".wrap_dn"},   32'(wrap_dn),   32'(x.wrap_dn));
    chk({lbl, ".dir_chg"},   32'(dir_chg),   32'(x.dir_chg));
    chk({lbl, ".locked"},    32'(locked),    32'(x.locked));
    chk({lbl, ".fault"},     32'(fault),     32'(x.fault));
    chk({lbl, ".err_cnt"},   32'(err_cnt),   32'(x.err_cnt));
    chk({lbl, ".wrap_cnt"},  32'(wrap_cnt),  32'(x.wrap_cnt));
    chk({lbl, ".err_small"}, 32'(s_err_cnt), 32'(x.err_small));
  endtask

  task automatic chk_all_zero(input string lbl);
    chk({lbl, ".step_err"},  32'(step_err),  32'd0);
    chk({lbl, ".wrap_up"},   32'(wrap_up),   32'd0);
    chk({lbl, ".wrap_dn"},   32'(wrap_dn),   32'd0);
    chk({lbl, ".dir_chg"},   32'(dir_chg),   32'd0);
    chk({lbl, ".locked"},    32'(locked),    32'd0);
    chk({lbl, ".fault"},     32'(fault),     32'd0);
    chk({lbl, ".err_cnt"},   32'(err_cnt),   32'd0);
    chk({lbl, ".wrap_cnt"},  32'(wrap_cnt),  32'd0);
    chk({lbl, ".err_small"}, 32'(s_err_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; ud = 1'b1; {q2, q1, q0} = 3'd0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Up count with one 7->0 wrap.
    for (int i = 0; i < 10; i++) step($sformatf("up%0d", i), 1'b1, 1'b0, 1'b1, 3'(i));
    chk("up.wrap_total", 32'(wrap_cnt), 32'd1);

    // Direction switch to down, then a 0->7 wrap.
    step("dn2", 1'b1, 1'b0, 1'b0, 3'd2);
    step("dn1", 1'b1, 1'b0, 1'b0, 3'd1);
    step("dn0", 1'b1, 1'b0, 1'b0, 3'd0);
    step("dn7", 1'b1, 1'b0, 1'b0, 3'd7);
    step("dn6", 1'b1, 1'b0, 1'b0, 3'd6);
    chk("dn.wrap_total", 32'(wrap_cnt), 32'd2);

    // Back up, then a skipped value 4->6 costs exactly one error.
    step("rv5", 1'b1, 1'b0, 1'b0, 3'd5);
    step("rv4", 1'b1, 1'b0, 1'b0, 3'd4);
    step("rv3", 1'b1, 1'b0, 1'b1, 3'd3);
    step("sk4", 1'b1, 1'b0, 1'b1, 3'd4);
    step("sk6", 1'b1, 1'b0, 1'b1, 3'd6);
    step("sk7", 1'b1, 1'b0, 1'b1, 3'd7);
    chk("skip.err_total", 32'(err_cnt), 32'd1);

    // Disabled for three cycles; resume from a jumped value without error.
    step("off0", 1'b0, 1'b0, 1'b1, 3'd0);
    step("off1", 1'b0, 1'b0, 1'b1, 3'd1);
    step("off2", 1'b0, 1'b0, 1'b1, 3'd2);
    step("on6",  1'b1, 1'b0, 1'b1, 3'd6);
    step("on7",  1'b1, 1'b0, 1'b1, 3'd7);
    step("on0",  1'b1, 1'b0, 1'b1, 3'd0);

    // Clear, then a stuck counter drives the monitor into FAULT.
    step("clr0", 1'b1, 1'b1, 1'b1, 3'd1);
    for (int i = 0; i < 4; i++) step($sformatf("stuck%0d", i), 1'b1, 1'b0, 1'b1, 3'd5);
    chk("stuck.fault", 32'(fault), 32'd1);
    chk("stuck.err_total", 32'(err_cnt), 32'd3);
    step("flt6", 1'b1, 1'b0, 1'b1, 3'd6);
    step("flt7", 1'b1, 1'b0, 1'b1, 3'd7);
    step("flten0", 1'b0, 1'b0, 1'b1, 3'd0);
    step("clr1", 1'b1, 1'b1, 1'b1, 3'd0);

    // Clear on the same edge as a mismatch suppresses the error.
    step("cm1", 1'b1, 1'b0, 1'b1, 3'd1);
    step("cm3", 1'b1, 1'b1, 1'b1, 3'd3);

    // Five non-consecutive errors: 2-bit counter saturates at 3, 8-bit reaches 5.
    step("sat0", 1'b1, 1'b0, 1'b1, 3'd0);
    step("sat2", 1'b1, 1'b0, 1'b1, 3'd2);
    step("sat3", 1'b1, 1'b0, 1'b1, 3'd3);
    step("sat5", 1'b1, 1'b0, 1'b1, 3'd5);
    step("sat6", 1'b1, 1'b0, 1'b1, 3'd6);
    step("sat0b", 1'b1, 1'b0, 1'b1, 3'd0);
    step("sat1", 1'b1, 1'b0, 1'b1, 3'd1);
    step("sat3b", 1'b1, 1'b0, 1'b1, 3'd3);
    step("sat4", 1'b1, 1'b0, 1'b1, 3'd4);
    step("sat6b", 1'b1, 1'b0, 1'b1, 3'd6);
    step("sat7", 1'b1, 1'b0, 1'b1, 3'd7);
    chk("sat.err_small", 32'(s_err_cnt), 32'd3);
    chk("sat.err_wide", 32'(err_cnt), 32'd5);

    // Asynchronous reset asserted between edges clears everything immediately.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ud_count_monitor.md
Name: ud_count_monitor

Overview:
- Downstream checker for the 3-bit synchronous up/down JK counter. It consumes the counter's q2/q1/q0 outputs and its ud direction input.
- Every cycle it checks that each new count is exactly previous ±1 mod 8, in the direction the counter was told.
- It flags step errors, wrap-around events and direction changes, and keeps saturating statistics.
- After repeated consecutive errors it latches a sticky fault for system-level supervision.

Parameters:
ERR_W, 8, width of saturating error counter err_cnt
WRAP_W, 8, width of saturating wrap counter wrap_cnt
FAULT_LIMIT, 3, consecutive step errors that force FAULT (legal range 1..15)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-low; clock and reset are one domain with the counter
en  input  1  monitor enable; tie to "counter not in reset"
clr  input  1  synchronous clear of statistics and fault
ud  input  1  counter direction (1 = up, 0 = down), same net that drives the counter
q2  input  1  counter bit 2 (MSB)
q1  input  1  counter bit 1
q0  input  1  counter bit 0
step_err  output  1  1-cycle pulse: sampled count is not the expected next value
wrap_up  output  1  1-cycle pulse: legal 7->0 step while counting up
wrap_dn  output  1  1-cycle pulse: legal 0->7 step while counting down
dir_chg  output  1  1-cycle pulse: ud differs from the value sampled on the previous edge
locked  output  1  level: tracking, with zero consecutive errors
fault  output  1  sticky level: FAULT_LIMIT consecutive errors seen
err_cnt  output  ERR_W  saturating count of step errors
wrap_cnt  output  WRAP_W  saturating count of wrap_up + wrap_dn events

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; q_prev=0, ud_prev=0, consec=0.
  - All pulses 0, locked=0, fault=0, err_cnt=0, wrap_cnt=0.
- Sampling:
  - On each rising edge, take {q2,q1,q0} and ud.
  - Expected value = q_prev+1 mod 8 if ud_prev=1, else q_prev-1 mod 8.
  - ud_prev is the ud captured alongside q_prev. This matches the counter: its value after edge k is built from ud before edge k.
- Output timing: all outputs are registered. A pulse is high for exactly the one cycle after the edge that sampled the event.
- States:
  - IDLE: pulses 0, locked=0. If en=1, capture q_prev/ud_prev and go to TRACK; no check on this first sample.
  - TRACK, en=1:
    - Compare the sample with the expected value.
    - Mismatch: step_err=1, err_cnt+1 (saturate at 2^ERR_W-1), consec+1. If consec reaches FAULT_LIMIT, go to FAULT and set fault=1.
    - Match: consec=0. wrap_up=1 if q_prev=7, q=0, ud_prev=1. wrap_dn=1 if q_prev=0, q=7, ud_prev=0. Either pulse increments wrap_cnt (saturating).
    - dir_chg=1 whenever ud != ud_prev, independent of match.
    - Always reload q_prev/ud_prev from the sample. A single skipped value therefore costs one error, e.g. 4->6->7 gives one error.
  - TRACK, en=0: go to IDLE; history dropped, statistics retained, no pulses.
  - FAULT: fault=1, locked=0. No checks, pulses or count updates. en is ignored. Exit only via clr or rst.
- locked = (state==TRACK) && (consec==0), registered.
- clr (synchronous):
  - Sets state=IDLE and zeroes err_cnt, wrap_cnt, consec and fault.
  - Beats a same-edge mismatch or wrap: that sample is not counted and gives no pulse.
  - rst overrides clr.
- Simultaneous events:
  - Mismatch with dir_chg: both pulse.
  - Wrap is only reported on a matching step; a mismatching 7->0 gives step_err only.
- Saturated counters hold their value; they never roll over.

Decomposition:
- Shared package/header:
  - Monitor state encoding: IDLE=2'd0, TRACK=2'd1, FAULT=2'd2.
  - Direction constants: UD_UP=1'b1, UD_DN=1'b0.
  - Count bounds: CNT_MAX=3'd7, CNT_MIN=3'd0.
- One sub-module, sat_counter: parameter W, ports clk, rst, clr, inc, q. Instantiated twice, for err_cnt and wrap_cnt.

Test Plan:
- Reset, en=1, ud=1, counter stream 0,1..7,0,1 -> no step_err; wrap_up exactly once, the cycle after 0 is sampled; wrap_cnt=1; locked=1 from the cycle after the second sample.
- ud switched to 0 mid-stream, then stream 2,1,0,7,6 -> dir_chg pulses once at the switch; wrap_dn once after 7 is sampled; wrap_cnt increments by 1; err_cnt stays 0.
- Up stream 3,4,6,7 -> one step_err on sample 6; err_cnt=1; locked drops for one cycle, then returns; fault=0.
- Stuck count 5,5,5,5 with ud=1 -> step_err on samples 2,3,4; FAULT entered after the third error; fault=1, err_cnt=3. Further legal counts give no pulses. clr=1 for one cycle -> fault=0, err_cnt=0, state IDLE.
- en=0 for 3 cycles, then en=1 with the count jumped 2->6 -> no step_err; tracking resumes from 6.
- ERR_W=2: five non-consecutive errors -> err_cnt saturates at 3. Then drive rst low between edges -> all outputs read 0 before the next edge.
